// File: rtl/f1_axil_wr_joiner.sv
// f1_axil_wr_joiner: joins AXI-Lite AW and W beats into single SoftReg write
// requests, one outstanding write at a time, answered with one B beat each.
// Optional feature macro: F1_AXIL_WSTRB_CHECK_EN -- partial-strobe writes are
// not forwarded and are answered with SLVERR.

// First-word-fall-through FIFO with registered storage and registered flags.
module f1_axil_wr_joiner_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head_c,
  output logic         empty,
  output logic         not_full
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_d;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // A pop frees the slot a same-cycle push may use, even when full.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL_CNT) || do_pop);
  assign head_c  = mem[rd_ptr];

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_d = count;
    case ({do_push, do_pop})
      2'b10:   count_d = count + CW'(1);
      2'b01:   count_d = count - CW'(1);
      default: count_d = count;
    endcase
  end

  // Pointers, occupancy and registered flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      not_full <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count    <= count_d;
      empty    <= (count_d == '0);
      not_full <= (count_d != FULL_CNT);
    end
  end

  // Storage array; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// AW/W join, SoftReg issue and B response.
module f1_axil_wr_joiner #(
  parameter int unsigned WR_ADDR_DEPTH = 2,
  parameter int unsigned WR_DATA_DEPTH = 2,
  parameter int unsigned SR_DATA_W     = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 awvalid,
  output logic                 awready,
  input  logic [31:0]          awaddr,
  input  logic                 wvalid,
  output logic                 wready,
  input  logic [31:0]          wdata,
  input  logic [3:0]           wstrb,
  output logic                 bvalid,
  input  logic                 bready,
  output logic [1:0]           bresp,
  output logic                 sr_req_valid,
  output logic                 sr_req_isWrite,
  output logic [31:0]          sr_req_addr,
  output logic [SR_DATA_W-1:0] sr_req_data,
  input  logic                 sr_req_grant
);
  localparam int unsigned AW_W = 32;
  localparam int unsigned WD_W = 36;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t          state;
  state_t          state_d;
  logic            join_c;
  logic [1:0]      resp_d;
  logic [AW_W-1:0] aw_head_c;
  logic [WD_W-1:0] w_head_c;
  logic            aw_empty;
  logic            w_empty;

  f1_axil_wr_joiner_fifo #(.DEPTH(WR_ADDR_DEPTH), .W(AW_W)) u_aw_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (awvalid && awready),
    .din      (awaddr),
    .pop      (join_c),
    .head_c   (aw_head_c),
    .empty    (aw_empty),
    .not_full (awready)
  );

  f1_axil_wr_joiner_fifo #(.DEPTH(WR_DATA_DEPTH), .W(WD_W)) u_w_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (wvalid && wready),
    .din      ({wstrb, wdata}),
    .pop      (join_c),
    .head_c   (w_head_c),
    .empty    (w_empty),
    .not_full (wready)
  );

`ifndef F1_AXIL_WSTRB_CHECK_EN
  logic unused_strb;
  assign unused_strb = ^w_head_c[35:32];
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next state, join strobe and response code.
  always_comb begin
    state_d = state;
    join_c  = 1'b0;
    resp_d  = bresp;
    case (state)
      IDLE: begin
        if (!aw_empty && !w_empty) begin
          join_c  = 1'b1;
          state_d = ISSUE;
          resp_d  = RESP_OKAY;
`ifdef F1_AXIL_WSTRB_CHECK_EN
          if (w_head_c[35:32] != 4'hF) begin
            state_d = RESP;
            resp_d  = RESP_SLVERR;
          end
`endif
        end
      end
      ISSUE: if (sr_req_grant) state_d = RESP;
      RESP:  if (bready)       state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered SoftReg and B outputs, derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_req_valid   <= 1'b0;
      sr_req_isWrite <= 1'b0;
      sr_req_addr    <= '0;
      sr_req_data    <= '0;
      bvalid         <= 1'b0;
      bresp          <= RESP_OKAY;
    end else begin
      sr_req_valid   <= (state_d == ISSUE);
      sr_req_isWrite <= (state_d == ISSUE);
      bvalid         <= (state_d == RESP);
      bresp          <= (state_d == RESP) ? resp_d : RESP_OKAY;
      if (join_c) begin
        sr_req_addr <= aw_head_c;
        sr_req_data <= SR_DATA_W'(w_head_c[31:0]);
      end
    end
  end
endmodule
